// File: rtl/seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
package seg_pkg;

  localparam int NDIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] hex7_t;
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg_scanner_if.sv
// Load channel of the scanner: new digit contents offered with a valid/ready handshake.
interface seg_scanner_if;
  import seg_pkg::*;

  logic [31:0]        data;
  logic [NDIGITS-1:0] dots;
  logic [NDIGITS-1:0] digit_en;
  logic               load_valid;
  logic               load_ready;

  modport master (
    output data,
    output dots,
    output digit_en,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data,
    input  dots,
    input  digit_en,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/seg_scanner_seg7.sv
// Hex nibble to active-low gfedcba pattern decoder.
module seg7
  import seg_pkg::*;
(
  input  nibble_t i_nib,
  output hex7_t   o_seg
);

  always_comb begin
    case (i_nib)
      4'h0:    o_seg = 7'h40;
      4'h1:    o_seg = 7'h79;
      4'h2:    o_seg = 7'h24;
      4'h3:    o_seg = 7'h30;
      4'h4:    o_seg = 7'h19;
      4'h5:    o_seg = 7'h12;
      4'h6:    o_seg = 7'h02;
      4'h7:    o_seg = 7'h78;
      4'h8:    o_seg = 7'h00;
      4'h9:    o_seg = 7'h10;
      4'hA:    o_seg = 7'h08;
      4'hB:    o_seg = 7'h03;
      4'hC:    o_seg = 7'h46;
      4'hD:    o_seg = 7'h21;
      4'hE:    o_seg = 7'h06;
      4'hF:    o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed eight-digit seven-segment driver with frame-synchronous,
// double-buffered content updates so the display never tears mid-frame.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
)
(
  input  logic         clk,
  input  logic         rstn,
  seg_scanner_if.slave bus,
  output seg_t         an,
  output seg_t         seg,
  output logic         frame_tick
);

  localparam int              CW        = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW:0]     BLANK_LIM = (CW + 1)'(BLANK);

  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [31:0]          r_pend_data;
  logic [NDIGITS-1:0]   r_pend_dots;
  logic [NDIGITS-1:0]   r_pend_en;
  logic                 r_load_ready;
  logic [31:0]          r_disp_data;
  logic [NDIGITS-1:0]   r_disp_dots;
  logic [NDIGITS-1:0]   r_disp_en;
  seg_t                 r_an;
  seg_t                 r_seg;
  logic                 r_frame_tick;

  logic                 w_frame_end;
  logic                 w_xfer;
  logic                 w_in_blank;
  nibble_t              w_nib;
  hex7_t                w_hex;
  seg_t                 w_an_nxt;
  seg_t                 w_seg_nxt;

  assign w_frame_end = (r_cnt == CNT_MAX) && (r_idx == 3'd7);
  assign w_xfer      = bus.load_valid && r_load_ready;
  assign w_in_blank  = ({1'b0, r_cnt} < BLANK_LIM);
  assign w_nib       = nibble_t'(r_disp_data >> {r_idx, 2'b00});

  seg7 u_seg7 (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  always_comb begin
    w_an_nxt  = SEG_OFF;
    w_seg_nxt = SEG_OFF;
    if (!w_in_blank && r_disp_en[r_idx]) begin
      w_an_nxt  = ~(8'h01 << r_idx);
      w_seg_nxt = {~r_disp_dots[r_idx], w_hex};
    end else begin
      w_an_nxt  = SEG_OFF;
      w_seg_nxt = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_an         <= SEG_OFF;
      r_seg        <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
      r_idx        <= (r_cnt == CNT_MAX) ? r_idx + 3'd1 : r_idx;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_tick <= w_frame_end;
    end
  end

  // Pending slot is full exactly while load_ready is low; it drains only at frame end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_load_ready <= 1'b1;
      r_pend_data  <= 32'd0;
      r_pend_dots  <= 8'd0;
      r_pend_en    <= 8'd0;
      r_disp_data  <= 32'd0;
      r_disp_dots  <= 8'd0;
      r_disp_en    <= 8'd0;
    end else if (w_frame_end && !r_load_ready) begin
      r_load_ready <= 1'b1;
      r_disp_data  <= r_pend_data;
      r_disp_dots  <= r_pend_dots;
      r_disp_en    <= r_pend_en;
    end else if (w_xfer) begin
      r_load_ready <= 1'b0;
      r_pend_data  <= bus.data;
      r_pend_dots  <= bus.dots;
      r_pend_en    <= bus.digit_en;
    end else begin
      r_load_ready <= r_load_ready;
    end
  end

  assign bus.load_ready = r_load_ready;
  assign an             = r_an;
  assign seg            = r_seg;
  assign frame_tick     = r_frame_tick;

endmodule

// File: tb/tb_seg_scanner.sv
// Directed test of seg_scanner with DIV=4, BLANK=1 (32-cycle frame).
module tb_seg_scanner;

  logic       clk;
  logic       rstn;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_tick;
  int         n_checks;
  int         n_errors;
  int         n;

  seg_scanner_if u_bus ();

  seg_scanner #(.DIV(4), .BLANK(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (u_bus),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (!frame_tick && cnt < 64);
    chk("tick_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    chk({tag, "_an"}, 32'(an), 32'(exp_an));
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    u_bus.data = 32'd0;
    u_bus.dots = 8'd0;
    u_bus.digit_en = 8'd0;
    u_bus.load_valid = 1'b0;
    cyc(2);
    chk_out("rst", 8'hFF, 8'hFF);
    chk("rst_ready", 32'(u_bus.load_ready), 32'd1);
    chk("rst_tick", 32'(frame_tick), 32'd0);

    // Dark after reset, first frame end after 32 edges
    rstn = 1'b1;
    wait_tick(n);
    chk("period_first", 32'(n), 32'd32);
    cyc(2);
    chk_out("dark", 8'hFF, 8'hFF);

    // Load 76543210, all digits on
    u_bus.data = 32'h76543210;
    u_bus.dots = 8'h00;
    u_bus.digit_en = 8'hFF;
    u_bus.load_valid = 1'b1;
    cyc(1);
    u_bus.load_valid = 1'b0;
    chk("ready_low", 32'(u_bus.load_ready), 32'd0);
    wait_tick(n);
    chk("ready_back", 32'(u_bus.load_ready), 32'd1);
    cyc(1);
    chk_out("s0_blank", 8'hFF, 8'hFF);
    cyc(1);
    chk_out("s0", 8'hFE, 8'hC0);
    cyc(3);
    chk_out("s1_blank", 8'hFF, 8'hFF);
    cyc(1);
    chk_out("s1", 8'hFD, 8'hF9);
    cyc(24);
    chk_out("s7", 8'h7F, 8'hF8);
    wait_tick(n);
    wait_tick(n);
    chk("period", 32'(n), 32'd32);

    // Single digit with decimal point
    u_bus.data = 32'h00000008;
    u_bus.dots = 8'h01;
    u_bus.digit_en = 8'h01;
    u_bus.load_valid = 1'b1;
    cyc(1);
    u_bus.load_valid = 1'b0;
    wait_tick(n);
    cyc(2);
    chk_out("one_s0", 8'hFE, 8'h00);
    cyc(4);
    chk_out("one_s1", 8'hFF, 8'hFF);
    cyc(24);
    chk_out("one_s7", 8'hFF, 8'hFF);

    // A mid-frame, then B held valid while pending is full
    wait_tick(n);
    cyc(10);
    u_bus.data = 32'hABCDEF01;
    u_bus.dots = 8'h00;
    u_bus.digit_en = 8'hFF;
    u_bus.load_valid = 1'b1;
    cyc(1);
    u_bus.data = 32'h12345678;
    u_bus.dots = 8'hFF;
    chk("a_taken", 32'(u_bus.load_ready), 32'd0);
    cyc(1);
    chk("old_persist_an", 32'(an), 32'hFF);
    chk("b_blocked", 32'(u_bus.load_ready), 32'd0);
    wait_tick(n);
    chk("a_applied_ready", 32'(u_bus.load_ready), 32'd1);
    cyc(1);
    chk("b_taken", 32'(u_bus.load_ready), 32'd0);
    cyc(1);
    u_bus.load_valid = 1'b0;
    chk_out("a_s0", 8'hFE, 8'hF9);
    cyc(4);
    chk_out("a_s1", 8'hFD, 8'hC0);
    wait_tick(n);
    cyc(2);
    chk_out("b_s0", 8'hFE, 8'h00);
    cyc(4);
    chk_out("b_s1", 8'hFD, 8'h78);

    // Reset with pending full drops it
    wait_tick(n);
    cyc(10);
    u_bus.data = 32'hFFFFFFFF;
    u_bus.dots = 8'hFF;
    u_bus.digit_en = 8'hFF;
    u_bus.load_valid = 1'b1;
    cyc(1);
    u_bus.load_valid = 1'b0;
    chk("c_taken", 32'(u_bus.load_ready), 32'd0);
    rstn = 1'b0;
    cyc(2);
    chk_out("rst2", 8'hFF, 8'hFF);
    chk("rst2_ready", 32'(u_bus.load_ready), 32'd1);
    chk("rst2_tick", 32'(frame_tick), 32'd0);
    rstn = 1'b1;
    cyc(2);
    chk_out("rst2_s0", 8'hFF, 8'hFF);
    wait_tick(n);
    chk("rst2_period", 32'(n), 32'd30);
    cyc(2);
    chk_out("drop_s0", 8'hFF, 8'hFF);
    cyc(4);
    chk_out("drop_s1", 8'hFF, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
